// File: rtl/bp_cce_pending_bits.sv
// bp_cce_pending_bits
//   Per-way-group saturating pending counters for the CCE. After reset an
//   init sweep zeroes every entry; traffic is accepted only once it is done.
//
// Ports:
//   clk_i, reset_i      clock, synchronous active-high reset
//   busy_o              high while in reset or during the init sweep
//   w_v_i, w_addr_i,    pending write: increment (pending_i=1) or
//   w_addr_bypass_i,    decrement (pending_i=0) the addressed entry, or
//   pending_i, clear_i  force it to zero (clear_i=1)
//   r_v_i, r_addr_i,    pending read request
//   r_addr_bypass_i
//   pending_v_o         read result valid, one cycle after an accepted read
//   pending_o, count_o  registered read result (count != 0, count)
//   error_o             sticky overflow/underflow flag

module bp_cce_pending_bits #(
    parameter int unsigned paddr_width_p       = 40,
    parameter int unsigned num_way_groups_p    = 64,
    parameter int unsigned block_offset_bits_p = 6,
    parameter int unsigned cnt_width_p         = 3
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    output logic                     busy_o,

    input  logic                     w_v_i,
    input  logic [paddr_width_p-1:0] w_addr_i,
    input  logic                     w_addr_bypass_i,
    input  logic                     pending_i,
    input  logic                     clear_i,

    input  logic                     r_v_i,
    input  logic [paddr_width_p-1:0] r_addr_i,
    input  logic                     r_addr_bypass_i,

    output logic                     pending_v_o,
    output logic                     pending_o,
    output logic [cnt_width_p-1:0]   count_o,
    output logic                     error_o
);

    localparam int unsigned idx_w = $clog2(num_way_groups_p);
    localparam logic [idx_w-1:0]       last_idx = idx_w'(num_way_groups_p - 1);
    localparam logic [cnt_width_p-1:0] cnt_max  = '1;
    localparam logic [cnt_width_p-1:0] cnt_one  = cnt_width_p'(1);

    typedef enum logic [1:0] {
        e_reset,
        e_clear,
        e_ready
    } state_e;

    state_e state, state_n;

    logic [idx_w-1:0]       sweep_idx;
    logic [cnt_width_p-1:0] mem [num_way_groups_p];

    logic                   ready;
    logic                   sweep_we;
    logic [idx_w-1:0]       w_idx, r_idx;
    logic [cnt_width_p-1:0] w_cur, w_new, rd_val;
    logic                   w_err;
    logic                   w_fire, r_fire;

    // Address bits outside the selected index are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{w_addr_i, r_addr_i};

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) state <= e_reset;
        else         state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        unique case (state)
            e_reset: state_n = e_clear;
            e_clear: state_n = (sweep_idx == last_idx) ? e_ready : e_clear;
            e_ready: state_n = e_ready;
            default: state_n = e_reset;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy_o   = (state != e_ready);
        ready    = (state == e_ready);
        sweep_we = (state == e_clear);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i)       sweep_idx <= '0;
        else if (sweep_we) sweep_idx <= sweep_idx + idx_w'(1);
    end

    // Index select, shared rule for both ports
    always_comb begin
        w_idx = w_addr_bypass_i ? w_addr_i[idx_w-1:0]
                                : w_addr_i[block_offset_bits_p +: idx_w];
        r_idx = r_addr_bypass_i ? r_addr_i[idx_w-1:0]
                                : r_addr_i[block_offset_bits_p +: idx_w];
    end

    assign w_fire = ready & w_v_i & ~reset_i;
    assign r_fire = ready & r_v_i & ~reset_i;

    // Saturating update: hold at the limit and flag the attempt
    always_comb begin
        w_cur = mem[w_idx];
        w_new = w_cur;
        w_err = 1'b0;
        if (clear_i) begin
            w_new = '0;
        end else if (pending_i) begin
            if (w_cur == cnt_max) w_err = 1'b1;
            else                  w_new = w_cur + cnt_one;
        end else begin
            if (w_cur == '0) w_err = 1'b1;
            else             w_new = w_cur - cnt_one;
        end
    end

    // Write-first: a same-cycle write to the read index is forwarded
    always_comb begin
        rd_val = mem[r_idx];
        if (w_fire && (w_idx == r_idx)) rd_val = w_new;
    end

    // Counter storage: no reset, the init sweep zeroes it
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if (sweep_we)    mem[sweep_idx] <= '0;
            else if (w_fire) mem[w_idx]     <= w_new;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pending_v_o <= 1'b0;
            pending_o   <= 1'b0;
            count_o     <= '0;
            error_o     <= 1'b0;
        end else begin
            pending_v_o <= r_fire;
            if (r_fire) begin
                count_o   <= rd_val;
                pending_o <= (rd_val != '0);
            end
            if (w_fire && w_err) error_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bp_cce_pending_bits.sv
// tb_bp_cce_pending_bits
//   Directed and random stimulus for bp_cce_pending_bits, checked every cycle
//   against a behavioural model of the counters, busy window and outputs.

module tb_bp_cce_pending_bits;

    localparam int NWG = 64;
    localparam int CMAX = 7;
    localparam int BUSY_AFTER_RESET = 65; // e_reset cycle + 64 sweep cycles

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        busy_o;
    logic        w_v_i = 1'b0;
    logic [39:0] w_addr_i = '0;
    logic        w_addr_bypass_i = 1'b0;
    logic        pending_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        r_v_i = 1'b0;
    logic [39:0] r_addr_i = '0;
    logic        r_addr_bypass_i = 1'b0;
    logic        pending_v_o;
    logic        pending_o;
    logic [2:0]  count_o;
    logic        error_o;

    int asserts = 0;
    int fails = 0;

    // Reference model
    int m_cnt [NWG];
    int m_busy_left = BUSY_AFTER_RESET;
    int m_err = 0;
    int m_pv = 0;
    int m_count = 0;

    always #5 clk = ~clk;

    bp_cce_pending_bits #(
        .paddr_width_p(40),
        .num_way_groups_p(64),
        .block_offset_bits_p(6),
        .cnt_width_p(3)
    ) dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .busy_o(busy_o),
        .w_v_i(w_v_i),
        .w_addr_i(w_addr_i),
        .w_addr_bypass_i(w_addr_bypass_i),
        .pending_i(pending_i),
        .clear_i(clear_i),
        .r_v_i(r_v_i),
        .r_addr_i(r_addr_i),
        .r_addr_bypass_i(r_addr_bypass_i),
        .pending_v_o(pending_v_o),
        .pending_o(pending_o),
        .count_o(count_o),
        .error_o(error_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        asserts++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic int idx_of(input logic [39:0] a, input bit byp);
        if (byp) return int'(a % 64);
        return int'((a / 64) % 64);
    endfunction

    // Random address whose non-bypass index is idx
    function automatic logic [39:0] addr_for(input int idx);
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return (r[39:0] & ~40'hFC0) | (40'(idx) << 6);
    endfunction

    // Random address whose bypass index is idx
    function automatic logic [39:0] byp_addr_for(input int idx);
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return (r[39:0] & ~40'h3F) | 40'(idx);
    endfunction

    // One clock: drive inputs, advance the model, check all outputs.
    task automatic step(input bit rst, input bit wv, input logic [39:0] wa, input bit wb,
                        input bit pend, input bit clr, input bit rv,
                        input logic [39:0] ra, input bit rb);
        int wi, ri;
        reset_i = rst; w_v_i = wv; w_addr_i = wa; w_addr_bypass_i = wb;
        pending_i = pend; clear_i = clr; r_v_i = rv; r_addr_i = ra; r_addr_bypass_i = rb;
        wi = idx_of(wa, wb);
        ri = idx_of(ra, rb);
        if (rst) begin
            m_busy_left = BUSY_AFTER_RESET;
            m_err = 0; m_pv = 0; m_count = 0;
        end else if (m_busy_left == 0) begin
            if (wv) begin
                if (clr) m_cnt[wi] = 0;
                else if (pend) begin
                    if (m_cnt[wi] == CMAX) m_err = 1; else m_cnt[wi]++;
                end else begin
                    if (m_cnt[wi] == 0) m_err = 1; else m_cnt[wi]--;
                end
            end
            m_pv = rv ? 1 : 0;
            if (rv) m_count = m_cnt[ri];
        end else begin
            m_pv = 0;
            m_busy_left--;
            if (m_busy_left == 0) foreach (m_cnt[i]) m_cnt[i] = 0;
        end
        @(posedge clk);
        #1;
        chk("busy", 32'(busy_o), (m_busy_left > 0) ? 1 : 0);
        chk("pending_v", 32'(pending_v_o), m_pv);
        chk("count", 32'(count_o), m_count);
        chk("pending", 32'(pending_o), (m_count != 0) ? 1 : 0);
        chk("error", 32'(error_o), m_err);
    endtask

    task automatic idle();
        step(0, 0, '0, 0, 0, 0, 0, '0, 0);
    endtask

    task automatic wr(input int idx, input bit pend, input bit clr);
        step(0, 1, addr_for(idx), 0, pend, clr, 0, '0, 0);
    endtask

    task automatic rd(input int idx);
        step(0, 0, '0, 0, 0, 0, 1, addr_for(idx), 0);
    endtask

    // Reset for one cycle, then count cycles that show busy; optionally
    // fire writes to index 3 throughout the busy window.
    task automatic reset_and_sweep(input bit write_during_busy);
        int hi, guard;
        step(1, 0, '0, 0, 0, 0, 0, '0, 0);
        hi = 0; guard = 0;
        do begin
            step(0, write_during_busy, addr_for(3), 0, 1, 0, write_during_busy, addr_for(3), 0);
            if (busy_o === 1'b1) hi++;
            guard++;
        end while (busy_o === 1'b1 && guard < 200);
        chk("busy_cycles", hi, 64);
    endtask

    initial begin
        int a, b;
        foreach (m_cnt[i]) m_cnt[i] = 0;

        // Power-up reset and sweep
        step(1, 0, '0, 0, 0, 0, 0, '0, 0);
        step(1, 0, '0, 0, 0, 0, 0, '0, 0);
        reset_and_sweep(0);
        rd(9);
        rd(63);

        // Three increments to 0x1000_0040 (index 1), then read both ways
        repeat (3) step(0, 1, 40'h10000040, 0, 1, 0, 0, '0, 0);
        step(0, 0, '0, 0, 0, 0, 1, 40'h10000040, 0);
        chk("idx1_count3", 32'(count_o), 3);
        step(0, 0, '0, 0, 0, 0, 1, 40'h10000040, 1);
        chk("idx0_bypass", 32'(count_o), 0);
        idle();

        // Forwarding: index 2 at 2, increment and read in the same cycle
        wr(2, 1, 0);
        wr(2, 1, 0);
        step(0, 1, addr_for(2), 0, 1, 0, 1, addr_for(2), 0);
        chk("fwd_count3", 32'(count_o), 3);

        // Overflow on index 5
        repeat (7) wr(5, 1, 0);
        chk("no_err_at_7", 32'(error_o), 0);
        wr(5, 1, 0);
        chk("err_overflow", 32'(error_o), 1);
        rd(5);
        chk("sat_count7", 32'(count_o), 7);

        // Underflow on index 6 after a fresh reset
        reset_and_sweep(0);
        step(0, 1, byp_addr_for(6), 1, 0, 0, 0, '0, 0);
        chk("err_underflow", 32'(error_o), 1);
        rd(6);
        chk("underflow_count0", 32'(count_o), 0);

        // Clear overrides pending_i on an entry at 4
        repeat (4) wr(10, 1, 0);
        rd(10);
        wr(10, 1, 1);
        rd(10);
        chk("clear_count0", 32'(count_o), 0);
        chk("clear_err_held", 32'(error_o), 1);

        // Reset mid-sweep restarts the 64-cycle sweep; busy writes dropped
        step(1, 0, '0, 0, 0, 0, 0, '0, 0);
        repeat (30) step(0, 1, addr_for(3), 0, 1, 0, 0, '0, 0);
        reset_and_sweep(1);
        rd(3);
        chk("busy_write_dropped", 32'(count_o), 0);

        // Random traffic over a small index range to provoke collisions
        for (int n = 0; n < 400; n++) begin
            a = $urandom_range(0, 7);
            b = ($urandom_range(0, 3) == 0) ? a : $urandom_range(0, 7);
            step(0, $urandom_range(0, 3) != 0,
                 ($urandom_range(0, 1) != 0) ? byp_addr_for(a) : addr_for(a),
                 0, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 1) != 0, addr_for(b), 0);
        end
        for (int i = 0; i < 8; i++) rd(i);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    // Note: the random loop passes w_addr_bypass_i=0 for all writes, so the
    // bypass-built addresses land at idx_of(addr,0) in both model and DUT.

endmodule

// File: doc/bp_cce_pending_bits.md
Name: bp_cce_pending_bits

Overview:
- Holds per-way-group pending counters for the CCE.
- Consumes the single arbitrated pending-write stream (microcode or message unit) and services microcode pending-bit reads.
- Each way group keeps a saturating counter; "pending" means the counter is non-zero.
- After reset, an init sweep clears every entry before the block accepts traffic.

Parameters:
paddr_width_p, 40, physical address width
num_way_groups_p, 64, number of way-group entries; power of two, at least 2
block_offset_bits_p, 6, address bits below the way-group index (64B block)
cnt_width_p, 3, pending counter width per entry (max value 7)

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
busy_o  out  1  high while the init sweep runs; inputs are ignored while high
w_v_i  in  1  pending write valid
w_addr_i  in  paddr_width_p  write address
w_addr_bypass_i  in  1  1: w_addr_i[lg(num_way_groups_p)-1:0] is the index directly; 0: index = w_addr_i[block_offset_bits_p +: lg(num_way_groups_p)]
pending_i  in  1  1: increment; 0: decrement
clear_i  in  1  with w_v_i, force entry to 0 (overrides pending_i)
r_v_i  in  1  read request
r_addr_i  in  paddr_width_p  read address
r_addr_bypass_i  in  1  index select for read, same rule as write
pending_v_o  out  1  read result valid, one cycle after r_v_i
pending_o  out  1  registered read result: counter != 0
count_o  out  cnt_width_p  registered counter value
error_o  out  1  sticky: increment at max or decrement at 0 attempted

Behaviour:
- FSM states: e_reset, e_clear, e_ready.
- reset_i=1 has priority over everything. It forces e_reset and clears the sweep index, pending_v_o, pending_o, count_o and error_o to 0. busy_o=1 while in reset.
- e_reset -> e_clear on the first cycle reset_i=0.
- e_clear writes 0 to entry[idx] and increments idx each cycle. It exits to e_ready after writing entry num_way_groups_p-1, so it lasts exactly num_way_groups_p cycles. busy_o=1 throughout.
- Reset asserted mid-sweep restarts the sweep from index 0.
- e_ready: busy_o=0; stays in e_ready until reset.
- While busy_o=1: w_v_i and r_v_i are ignored; pending_v_o=0; no counter changes; no error update.
- Write (e_ready, w_v_i=1): updates entry[w_idx] at the clock edge.
  - clear_i=1 -> 0.
  - Else pending_i=1: +1; if already 2^cnt_width_p-1, hold the value and set error_o.
  - Else pending_i=0: -1; if already 0, hold 0 and set error_o.
- error_o stays 1 until reset.
- Read (e_ready, r_v_i=1): the next cycle gives pending_v_o=1, count_o=entry value, pending_o=(count_o!=0).
  - If a write to the same index occurs in the same cycle, the read returns the post-write value (write-first forwarding).
- pending_v_o=0 in any cycle following a cycle with no accepted read. pending_o and count_o hold their last values.
- Index computation is identical for the read and write paths. Address bits outside the index are ignored.
- One write and one read per cycle, no stalls, no backpressure. The upstream arbiter guarantees at most one write per cycle.

Test Plan:
- Reset, then hold reset_i=0 -> busy_o=1 for exactly 64 cycles, then 0. Read of any index after that -> pending_v_o=1, count_o=0, pending_o=0.
- Three increments to addr 0x1000_0040 (index 1), then a read -> count_o=3, pending_o=1. The same address with w_addr_bypass_i=1 targets index 0 -> count_o=0.
- Write (pending_i=1) and read of the same index in the same cycle, from count 2 -> next cycle count_o=3 (forwarding).
- 8 increments to index 5 -> count_o=7, error_o=1 after the 8th. Decrement at 0 on index 6 -> count_o=0, error_o=1.
- clear_i=1 with pending_i=1 on an entry at 4 -> count_o=0, pending_o=0, error_o unchanged.
- Assert reset_i for 1 cycle at sweep cycle 30 -> busy_o stays high for 64 cycles after deassertion. Writes issued during busy have no effect (later read returns 0).
